// File: rtl/timer_unit_pkg.sv
// Shared definitions for the three-channel timer: register offsets, CTRL fields,
// bus mode encodings and the per-channel request/response structs.
package timer_unit_pkg;

   localparam int NUM_CH   = 3;
   localparam int NUM_REGS = 9;

   localparam logic [31:0] OFF_CTRL     = 32'd0;
   localparam logic [31:0] OFF_STATUS   = 32'd1;
   localparam logic [31:0] OFF_PRESCALE = 32'd2;
   localparam logic [31:0] OFF_CMP0     = 32'd3;
   localparam logic [31:0] OFF_CNT0     = 32'd6;

   localparam int CTRL_EN_LSB  = 0;
   localparam int CTRL_PER_LSB = 3;
   localparam int CTRL_W       = 6;

   typedef enum logic [1:0] {
      BUS_IDLE  = 2'b00,
      BUS_READ  = 2'b01,
      BUS_WRITE = 2'b10,
      BUS_RSVD  = 2'b11
   } bus_mode_e;

   typedef struct packed {
      logic        tick;
      logic        en;
      logic        periodic;
      logic        cmp_we;
      logic        cnt_we;
      logic        clr;
      logic [31:0] wdata;
   } chan_req_t;

   typedef struct packed {
      logic [31:0] count;
      logic [31:0] compare;
      logic        pending;
      logic        auto_dis;
   } chan_rsp_t;

endpackage

// File: rtl/timer_unit_channel.sv
// One timer channel: COUNT/COMPARE registers, match detection and pending flag.
// Raises auto_dis on a one-shot match so the top can clear the enable bit.
module timer_channel
   import timer_unit_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  chan_req_t req,
   output chan_rsp_t rsp
);

   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        pending_q, pending_d;
   logic        match;

   always_comb begin
      // a software COUNT write overrides both the increment and a match
      match     = req.tick & req.en & ~req.cnt_we & (count_q == compare_q);
      compare_d = req.cmp_we ? req.wdata : compare_q;
      count_d   = count_q;
      if (req.cnt_we)
         count_d = req.wdata;
      else if (req.tick && req.en)
         count_d = match ? 32'd0 : count_q + 32'd1;
      pending_d = pending_q;
      if (match)
         pending_d = 1'b1;
      else if (req.clr)
         pending_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         compare_q <= '0;
         pending_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      rsp          = '0;
      rsp.count    = count_q;
      rsp.compare  = compare_q;
      rsp.pending  = pending_q;
      rsp.auto_dis = match & ~req.periodic;
   end

endmodule

// File: rtl/timer_unit.sv
// Three-channel memory-mapped timer on a shared tri-state word bus.
// Optional prescaler selected by defining TIMER_UNIT_PRESCALER_EN; otherwise every cycle ticks.
module timer_unit
   import timer_unit_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_5000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [2:0]  irq_n,
   inout  wire  [31:0] data_bus_data,
   input  logic [31:0] data_bus_addr,
   input  logic [1:0]  data_bus_mode
);

   logic [31:0]       off;
   logic              in_range, rd_en, wr_en;
   logic [31:0]       wdata, rdata, presc_rd;
   logic              tick;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [NUM_CH-1:0] pending;
   chan_req_t         req [NUM_CH];
   chan_rsp_t         rsp [NUM_CH];

   // unsigned subtraction folds below-base addresses into the out-of-range case
   assign off      = data_bus_addr - BASE_ADDR;
   assign in_range = off < 32'(NUM_REGS);
   assign rd_en    = ~reset & in_range & (data_bus_mode == BUS_READ);
   assign wr_en    = in_range & (data_bus_mode == BUS_WRITE);
   assign wdata    = data_bus_data;

`ifdef TIMER_UNIT_PRESCALER_EN
   logic [15:0] presc_q, presc_d, pcnt_q, pcnt_d;

   always_comb begin
      tick    = (pcnt_q == presc_q);
      pcnt_d  = tick ? 16'd0 : pcnt_q + 16'd1;
      presc_d = presc_q;
      if (wr_en && off == OFF_PRESCALE) begin
         presc_d = wdata[15:0];
         pcnt_d  = 16'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         pcnt_q  <= '0;
      end else begin
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
      end
   end

   assign presc_rd = {16'h0000, presc_q};
`else
   assign tick     = 1'b1;
   assign presc_rd = '0;
`endif

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         req[k]          = '0;
         req[k].tick     = tick;
         req[k].en       = ctrl_q[CTRL_EN_LSB+k];
         req[k].periodic = ctrl_q[CTRL_PER_LSB+k];
         req[k].cmp_we   = wr_en && (off == OFF_CMP0 + 32'(k));
         req[k].cnt_we   = wr_en && (off == OFF_CNT0 + 32'(k));
         req[k].clr      = wr_en && (off == OFF_STATUS) && wdata[k];
         req[k].wdata    = wdata;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      timer_channel u_ch (
         .clk   (clk),
         .reset (reset),
         .req   (req[g]),
         .rsp   (rsp[g])
      );
      assign pending[g] = rsp[g].pending;
   end

   // a CTRL write in the same edge as a one-shot auto-clear takes precedence
   always_comb begin
      ctrl_d = ctrl_q;
      for (int k = 0; k < NUM_CH; k++)
         if (rsp[k].auto_dis) ctrl_d[CTRL_EN_LSB+k] = 1'b0;
      if (wr_en && off == OFF_CTRL)
         ctrl_d = wdata[CTRL_W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ctrl_q <= '0;
      else       ctrl_q <= ctrl_d;
   end

   always_comb begin
      rdata = '0;
      if (off == OFF_CTRL)     rdata = {26'd0, ctrl_q};
      if (off == OFF_STATUS)   rdata = {29'd0, pending};
      if (off == OFF_PRESCALE) rdata = presc_rd;
      for (int k = 0; k < NUM_CH; k++) begin
         if (off == OFF_CMP0 + 32'(k)) rdata = rsp[k].compare;
         if (off == OFF_CNT0 + 32'(k)) rdata = rsp[k].count;
      end
   end

   assign data_bus_data = rd_en ? rdata : 32'hzzzz_zzzz;
   assign irq_n         = ~pending;

endmodule

// File: tb/tb_timer_unit.sv
// Directed bench for timer_unit: register table plus hand-timed interrupt sequences.
// A pull-up on the bus makes an undriven bus read as all ones.
module tb_timer_unit;
   import timer_unit_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_5000;
   localparam logic [31:0] ZV   = 32'hFFFF_FFFF;
`ifdef TIMER_UNIT_PRESCALER_EN
   localparam bit PRE_EN = 1'b1;
`else
   localparam bit PRE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  irq_n;
   wire  [31:0] data_bus_data;
   logic [31:0] addr = '0;
   logic [1:0]  mode = 2'b00;
   logic [31:0] tb_drv = '0;
   logic        tb_oe = 1'b0;
   int          pass_cnt = 0;
   int          total = 0;

   always #5 clk = ~clk;

   pullup (data_bus_data);
   assign data_bus_data = tb_oe ? tb_drv : 32'hzzzz_zzzz;

   timer_unit #(.BASE_ADDR(BASE)) dut (
      .clk           (clk),
      .reset         (reset),
      .irq_n         (irq_n),
      .data_bus_data (data_bus_data),
      .data_bus_addr (addr),
      .data_bus_mode (mode)
   );

   typedef struct {
      bit          is_wr;
      logic [31:0] off;
      logic [31:0] data;
      logic [31:0] exp;
      string       nm;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic bus(input logic [1:0] m, input logic [31:0] off, input logic [31:0] d);
      @(negedge clk);
      mode = m; addr = BASE + off; tb_drv = d; tb_oe = 1'b1;
      @(posedge clk);
      #1;
      mode = 2'b00; tb_oe = 1'b0;
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      bus(2'b10, off, d);
   endtask

   task automatic rd(input logic [31:0] off, output logic [31:0] d);
      @(negedge clk);
      mode = 2'b01; addr = BASE + off;
      #1;
      d = data_bus_data;
      mode = 2'b00;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vec_t        tv[$];
      logic [31:0] v;
      int          m;

      // reset state
      #1;
      chk("rst_irq_n", {29'd0, irq_n}, 32'd7);
      rd(OFF_CTRL, v);
      chk("rst_bus_z", v, ZV);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         rd(32'(i), v);
         chk($sformatf("post_rst_reg%0d", i), v, 32'd0);
      end
      chk("post_rst_irq_n", {29'd0, irq_n}, 32'd7);

      // register table, all channels disabled
      tv.push_back('{1'b1, 32'd3, 32'hDEAD_BEEF, 32'd0, "w_cmp0"});
      tv.push_back('{1'b0, 32'd3, 32'd0, 32'hDEAD_BEEF, "cmp0"});
      tv.push_back('{1'b1, 32'd5, 32'h1234_5678, 32'd0, "w_cmp2"});
      tv.push_back('{1'b0, 32'd5, 32'd0, 32'h1234_5678, "cmp2"});
      tv.push_back('{1'b1, 32'd7, 32'hA5A5_A5A5, 32'd0, "w_cnt1"});
      tv.push_back('{1'b0, 32'd7, 32'd0, 32'hA5A5_A5A5, "cnt1"});
      tv.push_back('{1'b1, 32'd0, 32'hFFFF_FFC0, 32'd0, "w_ctrl_hi"});
      tv.push_back('{1'b0, 32'd0, 32'd0, 32'd0, "ctrl_hi"});
      tv.push_back('{1'b1, 32'd0, 32'h0000_0038, 32'd0, "w_ctrl_per"});
      tv.push_back('{1'b0, 32'd0, 32'd0, 32'h0000_0038, "ctrl_per"});
      tv.push_back('{1'b1, 32'd1, 32'hFFFF_FFFF, 32'd0, "w_status"});
      tv.push_back('{1'b0, 32'd1, 32'd0, 32'd0, "status"});
      tv.push_back('{1'b1, 32'd2, 32'hFFFF_0007, 32'd0, "w_presc"});
      tv.push_back('{1'b0, 32'd2, 32'd0, PRE_EN ? 32'd7 : 32'd0, "presc"});
      tv.push_back('{1'b0, 32'd7, 32'd0, 32'hA5A5_A5A5, "cnt1_hold"});
      tv.push_back('{1'b0, 32'd9, 32'd0, ZV, "oor_read_z"});
      foreach (tv[i]) begin
         if (tv[i].is_wr) wr(tv[i].off, tv[i].data);
         else begin
            rd(tv[i].off, v);
            chk(tv[i].nm, v, tv[i].exp);
         end
      end

      // idle modes do not drive or write
      @(negedge clk);
      mode = 2'b00; addr = BASE;
      #1 chk("idle00_z", data_bus_data, ZV);
      bus(2'b11, OFF_CMP0, 32'h0000_0055);
      rd(OFF_CMP0, v);
      chk("mode11_no_write", v, 32'hDEAD_BEEF);
      wr(32'd12, 32'h0000_0077);
      rd(OFF_CMP0, v);
      chk("oor_write_ignored", v, 32'hDEAD_BEEF);

      // periodic ch0, match every 5 ticks
      do_reset();
      wr(OFF_PRESCALE, 32'd0);
      wr(OFF_CMP0, 32'd4);
      wr(OFF_CTRL, 32'h09);
      for (int e = 1; e <= 5; e++) begin
         @(posedge clk); #1;
         chk($sformatf("per_irq_e%0d", e), {31'd0, irq_n[0]}, (e < 5) ? 32'd1 : 32'd0);
      end
      wr(OFF_STATUS, 32'd1);
      chk("per_clr_e6", {31'd0, irq_n[0]}, 32'd1);
      for (int e = 7; e <= 10; e++) begin
         @(posedge clk); #1;
         chk($sformatf("per_irq_e%0d", e), {31'd0, irq_n[0]}, (e < 10) ? 32'd1 : 32'd0);
      end
      // clear, then clear again on the exact match edge: set wins
      wr(OFF_STATUS, 32'd1);
      chk("per_clr_e11", {31'd0, irq_n[0]}, 32'd1);
      repeat (3) @(posedge clk);
      wr(OFF_STATUS, 32'd1);
      chk("set_beats_clr_irq", {31'd0, irq_n[0]}, 32'd0);
      rd(OFF_STATUS, v);
      chk("set_beats_clr_status", v, 32'd1);

      // one-shot ch1 with prescale 3
      do_reset();
      wr(OFF_PRESCALE, 32'd3);
      wr(OFF_CMP0 + 32'd1, 32'd2);
      wr(OFF_CTRL, 32'h02);
      m = PRE_EN ? 12 : 5;
      for (int e = 3; e <= m; e++) begin
         @(posedge clk); #1;
         if (e >= m - 1)
            chk($sformatf("oneshot_irq_e%0d", e), {31'd0, irq_n[1]}, (e < m) ? 32'd1 : 32'd0);
      end
      rd(OFF_CTRL, v);
      chk("oneshot_ctrl_clr", v, 32'd0);
      rd(OFF_CNT0 + 32'd1, v);
      chk("oneshot_cnt0", v, 32'd0);
      repeat (10) @(posedge clk);
      rd(OFF_CNT0 + 32'd1, v);
      chk("oneshot_cnt_hold", v, 32'd0);
      rd(OFF_STATUS, v);
      chk("oneshot_status", v, 32'd2);

      // ch2 wraps from all ones, then matches 17 ticks later
      do_reset();
      wr(OFF_CNT0 + 32'd2, 32'hFFFF_FFFF);
      wr(OFF_CMP0 + 32'd2, 32'h10);
      wr(OFF_CTRL, 32'h04);
      @(posedge clk);
      rd(OFF_CNT0 + 32'd2, v);
      chk("wrap_cnt", v, 32'd0);
      for (int e = 2; e <= 18; e++) begin
         @(posedge clk); #1;
         if (e >= 17)
            chk($sformatf("wrap_irq_e%0d", e), {31'd0, irq_n[2]}, (e < 18) ? 32'd1 : 32'd0);
      end

      // COUNT write on a tick edge wins over increment
      do_reset();
      wr(OFF_CMP0, 32'd1000);
      wr(OFF_CTRL, 32'h01);
      wr(OFF_CNT0, 32'd100);
      rd(OFF_CNT0, v);
      chk("cnt_write_wins", v, 32'd100);

      // CTRL write on the one-shot match edge wins over auto-clear
      do_reset();
      wr(OFF_CMP0, 32'd2);
      wr(OFF_CTRL, 32'h01);
      repeat (2) @(posedge clk);
      wr(OFF_CTRL, 32'h01);
      rd(OFF_CTRL, v);
      chk("ctrl_write_wins", v, 32'd1);
      rd(OFF_STATUS, v);
      chk("ctrl_write_match_pend", v, 32'd1);

      // reset mid-count aborts with nothing pending afterwards
      do_reset();
      wr(OFF_CMP0, 32'd3);
      wr(OFF_CTRL, 32'h09);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 chk("midrst_irq_n", {29'd0, irq_n}, 32'd7);
      rd(OFF_CNT0, v);
      chk("midrst_bus_z", v, ZV);
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(posedge clk);
      #1 chk("midrst_release_irq_n", {29'd0, irq_n}, 32'd7);
      rd(OFF_CNT0, v);
      chk("midrst_cnt", v, 32'd0);

      // PRESCALE writability depends on the build
      wr(OFF_PRESCALE, 32'd5);
      rd(OFF_PRESCALE, v);
      chk("presc_build", v, PRE_EN ? 32'd5 : 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
